// File: rtl/instr_fetch_issue.sv
// Multi-cycle MIPS instruction fetch/issue unit: fetches one word, holds it in IR,
// drives decoded fields while the datapath consumes it, then computes the next PC.
module instr_fetch_issue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch,
  input  logic        branch_taken,
  input  logic [31:0] jr_target,
  output logic        instr_valid,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm,
  output logic [31:0] pc_out,
  output logic        align_err
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_CAPTURE = 2'd1,
    S_ISSUE   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic        [31:0] r_pc;
  logic        [31:0] r_ir;
  logic               r_align_err;
  logic               w_advance;
  logic               w_is_jr;
  logic               w_is_j;
  logic               w_jr_misaligned;
  logic        [31:0] w_pc4;
  logic signed [31:0] w_br_off;
  logic        [31:0] w_next_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_advance   = 1'b0;
    case (r_state)
      S_FETCH:   w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (!stall) begin
          w_advance   = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      default:   w_state_nxt = S_FETCH;
    endcase
  end

  // Next-PC selection; only consumed when w_advance is high.
  assign w_is_jr         = (r_ir[31:26] == 6'h00) && (r_ir[5:0] == 6'h08);
  assign w_is_j          = (r_ir[31:26] == 6'h02) || (r_ir[31:26] == 6'h03);
  assign w_jr_misaligned = |jr_target[1:0];
  assign w_pc4           = r_pc + 32'd4;
  assign w_br_off        = {{14{r_ir[15]}}, r_ir[15:0], 2'b00};

  always_comb begin
    w_next_pc = w_pc4;
    if (w_is_jr)                    w_next_pc = {jr_target[31:2], 2'b00};
    else if (w_is_j)                w_next_pc = {w_pc4[31:28], r_ir[25:0], 2'b00};
    else if (branch && branch_taken) w_next_pc = w_pc4 + unsigned'(w_br_off);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_ir        <= 32'd0;
      r_align_err <= 1'b0;
    end else begin
      if (r_state == S_CAPTURE) r_ir <= imem_rdata;
      if (w_advance) begin
        r_pc <= w_next_pc;
        if (w_is_jr && w_jr_misaligned) r_align_err <= 1'b1;
      end
    end
  end

  // The state register already sits in FETCH during reset, so the strobe is
  // masked by reset itself to stay low until reset is released.
  assign imem_req    = (r_state == S_FETCH) && !reset;
  assign imem_addr   = r_pc;
  assign instr_valid = (r_state == S_ISSUE);
  assign opcode      = r_ir[31:26];
  assign rs          = r_ir[25:21];
  assign rt          = r_ir[20:16];
  assign rd          = r_ir[15:11];
  assign shamt       = r_ir[10:6];
  assign funct       = r_ir[5:0];
  assign imm         = r_ir[15:0];
  assign pc_out      = r_pc;
  assign align_err   = r_align_err;

endmodule

// File: tb/tb_instr_fetch_issue.sv
// Bench for instr_fetch_issue: directed scenarios followed by random instruction
// streams, checked against an instruction-level next-PC model.
module tb_instr_fetch_issue;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch;
  logic        branch_taken;
  logic [31:0] jr_target;
  logic        instr_valid;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [31:0] pc_out;
  logic        align_err;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_pc;
  logic        exp_err;

  instr_fetch_issue #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .stall(stall), .branch(branch),
    .branch_taken(branch_taken), .jr_target(jr_target),
    .instr_valid(instr_valid), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
    .shamt(shamt), .funct(funct), .imm(imm), .pc_out(pc_out),
    .align_err(align_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Instruction-level reference: where the PC goes after this word issues.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] w,
                                             input logic br, input logic tk,
                                             input logic [31:0] jrt);
    logic [31:0] pc4;
    int          op, fn, off;
    pc4 = pc + 32'd4;
    op  = int'(w >> 26);
    fn  = int'(w & 32'h3F);
    if (op == 0 && fn == 8)      return jrt - (jrt % 4);
    if (op == 2 || op == 3)      return (pc4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 4);
    if (br && tk) begin
      off = int'(w & 32'hFFFF);
      if (off >= 32768) off = off - 65536;
      return pc4 + 32'(off * 4);
    end
    return pc4;
  endfunction

  task automatic check_fetch();
    check("fetch_req",   {31'd0, imem_req}, 32'd1);
    check("fetch_addr",  imem_addr, exp_pc);
    check("fetch_valid", {31'd0, instr_valid}, 32'd0);
    check("fetch_pc",    pc_out, exp_pc);
    check("align_err",   {31'd0, align_err}, {31'd0, exp_err});
  endtask

  task automatic check_issue(input logic [31:0] w);
    check("iss_valid",  {31'd0, instr_valid}, 32'd1);
    check("iss_req",    {31'd0, imem_req}, 32'd0);
    check("iss_opcode", {26'd0, opcode}, w >> 26);
    check("iss_rs",     {27'd0, rs},     (w >> 21) & 32'h1F);
    check("iss_rt",     {27'd0, rt},     (w >> 16) & 32'h1F);
    check("iss_rd",     {27'd0, rd},     (w >> 11) & 32'h1F);
    check("iss_shamt",  {27'd0, shamt},  (w >> 6) & 32'h1F);
    check("iss_funct",  {26'd0, funct},  w & 32'h3F);
    check("iss_imm",    {16'd0, imm},    w & 32'hFFFF);
    check("iss_pc",     pc_out, exp_pc);
  endtask

  // Entered at a sample point inside FETCH; returns at the sample point of the following FETCH.
  task automatic do_instr(input logic [31:0] w, input int nstall, input logic br,
                          input logic tk, input logic [31:0] jrt);
    logic [31:0] nxt;
    check_fetch();
    imem_rdata = $urandom; stall = 1'($urandom); branch = 1'($urandom);
    branch_taken = 1'($urandom); jr_target = $urandom;
    @(negedge clk);
    check("cap_req",   {31'd0, imem_req}, 32'd0);
    check("cap_valid", {31'd0, instr_valid}, 32'd0);
    imem_rdata = w;
    @(negedge clk);
    imem_rdata = $urandom;
    for (int s = 0; s <= nstall; s++) begin
      check_issue(w);
      if (s < nstall) begin
        stall = 1'b1; branch = 1'($urandom); branch_taken = 1'($urandom); jr_target = $urandom;
        @(negedge clk);
      end
    end
    stall = 1'b0; branch = br; branch_taken = tk; jr_target = jrt;
    nxt = model_next(exp_pc, w, br, tk, jrt);
    if ((w >> 26) == 0 && (w & 32'h3F) == 8 && (jrt % 4) != 0) exp_err = 1'b1;
    @(negedge clk);
    stall = 1'($urandom); branch = 1'($urandom); branch_taken = 1'($urandom); jr_target = $urandom;
    exp_pc = nxt;
  endtask

  localparam logic [31:0] ADD = 32'h0000_0020;
  localparam logic [31:0] JR  = 32'h03E0_0008;
  localparam logic [31:0] BEQ = 32'h1022_FFFE;

  logic [31:0] w;
  int          k;

  initial begin
    reset = 1'b1; imem_rdata = '0; stall = 1'b0; branch = 1'b0;
    branch_taken = 1'b0; jr_target = '0;
    exp_pc = RST_PC; exp_err = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req",    {31'd0, imem_req}, 32'd0);
    check("rst_valid",  {31'd0, instr_valid}, 32'd0);
    check("rst_aerr",   {31'd0, align_err}, 32'd0);
    check("rst_opcode", {26'd0, opcode}, 32'd0);
    check("rst_pc",     pc_out, RST_PC);
    reset = 1'b0;
    #1;

    // Sequential adds, then beq taken / not taken at PC=0x10
    repeat (4) do_instr(ADD, 0, 1'b0, 1'b0, 32'd0);
    do_instr(BEQ, 0, 1'b1, 1'b1, 32'd0);
    check("beq_taken", exp_pc, 32'h0000_000C);
    do_instr(ADD, 0, 1'b0, 1'b0, 32'd0);
    do_instr(BEQ, 0, 1'b1, 1'b0, 32'd0);
    check("beq_not_taken", exp_pc, 32'h0000_0014);

    // jr to 0x4000_0000, j with target field 0x10, misaligned jr
    do_instr(JR, 0, 1'b1, 1'b1, 32'h4000_0000);
    do_instr(32'h0800_0010, 0, 1'b1, 1'b1, 32'd0);
    check("j_target", exp_pc, 32'h4000_0040);
    do_instr(JR, 0, 1'b0, 1'b0, 32'h0000_0123);
    check("jr_target", exp_pc, 32'h0000_0120);

    // Five-cycle stall, then wrap from 0xFFFF_FFFC
    do_instr(32'h0123_4820, 5, 1'b0, 1'b0, 32'd0);
    do_instr(JR, 0, 1'b0, 1'b0, 32'hFFFF_FFFC);
    do_instr(ADD, 0, 1'b0, 1'b0, 32'd0);
    check("wrap", exp_pc, 32'h0000_0000);
    do_instr(JR, 2, 1'b0, 1'b0, 32'h0000_0203);

    // Reset asserted in the middle of CAPTURE
    check_fetch();
    imem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("midrst_req",   {31'd0, imem_req}, 32'd0);
    check("midrst_valid", {31'd0, instr_valid}, 32'd0);
    check("midrst_aerr",  {31'd0, align_err}, 32'd0);
    check("midrst_addr",  imem_addr, RST_PC);
    check("midrst_funct", {26'd0, funct}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    exp_pc = RST_PC; exp_err = 1'b0;

    // Random instruction stream
    for (int i = 0; i < 60; i++) begin
      w = $urandom;
      k = $urandom_range(0, 4);
      case (k)
        0: begin w[31:26] = 6'h00; if (w[5:0] == 6'h08) w[5:0] = 6'h09; end
        1: begin w[31:26] = 6'h00; w[5:0] = 6'h08; end
        2: w[31:26] = 6'($urandom_range(2, 3));
        3: w[31:26] = 6'($urandom_range(4, 5));
        default: ;
      endcase
      do_instr(w, $urandom_range(0, 3), 1'($urandom), 1'($urandom),
               ($urandom_range(0, 1) != 0) ? ($urandom & 32'hFFFF_FFFC) : $urandom);
    end
    check_fetch();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
